// File: rtl/fib_mon_pkg.sv
// Shared types and defaults for the fib-14 trace monitor.
// Holds the monitor state encoding, the violation cause codes and the default sizing.
package fib_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        V_NONE         = 2'd0,
        V_ILLEGAL_STEP = 2'd1,
        V_M_CHANGED    = 2'd2,
        V_INVARIANT    = 2'd3
    } viol_e;

    localparam int DEF_W           = 11;
    localparam int DEF_M_INIT      = 300;
    localparam int DEF_STALL_LIMIT = 8;

endpackage

// File: rtl/fib_step_checker.sv
// Combinational classifier for one a/j/m update of the fib-14 stage.
// Compares the current sample against the previous one and names the step kind or its violation.
module fib_step_checker
    import fib_mon_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         p_sel,
    input  logic [W-1:0] p_a,
    input  logic [W-1:0] p_j,
    input  logic [W-1:0] p_m,
    input  logic [W-1:0] a,
    input  logic [W-1:0] j,
    input  logic [W-1:0] m,
    output logic         advance,
    output logic         stall,
    output logic         terminal,
    output viol_e        code
);

    localparam logic [W-1:0] W_ONES = {W{1'b1}};
    localparam logic [W-1:0] W_ZERO = {W{1'b0}};
    localparam logic [W-1:0] W_ONE  = {{(W-1){1'b0}}, 1'b1};

    logic same_s;
    logic live_s;

    // Step classification; wrapping +1 results are excluded so an upstream wrap is illegal.
    always_comb begin
        same_s   = (a == p_a) && (j == p_j);
        live_s   = (p_j <= p_m);
        terminal = !live_s && same_s;
        stall    = live_s && !p_sel && (p_a == W_ZERO) && same_s;
        if (!live_s) begin
            advance = 1'b0;
        end else if (p_sel) begin
            advance = (p_a != W_ONES) && (p_j != W_ONES) &&
                      (a == p_a + W_ONE) && (j == p_j + W_ONE);
        end else begin
            advance = (p_a != W_ZERO) && (p_j != W_ONES) &&
                      (a == p_a - W_ONE) && (j == p_j + W_ONE);
        end

        if (m != p_m) begin
            code = V_M_CHANGED;
        end else if ((j > m) && (a > m)) begin
            code = V_INVARIANT;
        end else if (!(advance || stall || terminal)) begin
            code = V_ILLEGAL_STEP;
        end else begin
            code = V_NONE;
        end
    end

endmodule

// File: rtl/fib_trace_monitor.sv
// Passive observer of the fib-14 counter stage: tracks its run state, step/stall statistics
// and a sticky first-cause violation, all registered one clock after the exposing sample.
module fib_trace_monitor
    import fib_mon_pkg::*;
#(
    parameter int W           = DEF_W,
    parameter int M_INIT      = DEF_M_INIT,
    parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         dut_rst,
    input  logic         selector,
    input  logic [W-1:0] a,
    input  logic [W-1:0] j,
    input  logic [W-1:0] m,
    output logic [1:0]   state,
    output logic [W-1:0] step_cnt,
    output logic [7:0]   stall_cnt,
    output logic [W-1:0] a_max,
    output logic [W-1:0] a_min,
    output logic         stuck,
    output logic         viol,
    output logic [1:0]   viol_code
);

    localparam logic [W-1:0] W_ONES    = {W{1'b1}};
    localparam logic [W-1:0] W_ZERO    = {W{1'b0}};
    localparam logic [W-1:0] W_ONE     = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] M_INIT_V  = W'(M_INIT);
    localparam logic [7:0]   STALL_MAX = 8'(STALL_LIMIT);

    state_e       state_r, state_s;
    logic [W-1:0] step_cnt_r, step_cnt_s;
    logic [7:0]   stall_cnt_r, stall_cnt_s;
    logic [W-1:0] a_max_r, a_max_s;
    logic [W-1:0] a_min_r, a_min_s;
    logic         stuck_r, stuck_s;
    logic         viol_r, viol_s;
    viol_e        code_r, code_s;

    // valid_r is low until the first edge after rst, so that edge only captures the prev sample.
    logic         valid_r;
    logic         p_sel_r;
    logic [W-1:0] p_a_r, p_j_r, p_m_r;

    logic         chk_advance_s, chk_stall_s, chk_terminal_s;
    viol_e        chk_code_s;
    logic         start_s;

    fib_step_checker #(.W(W)) u_checker (
        .p_sel    (p_sel_r),
        .p_a      (p_a_r),
        .p_j      (p_j_r),
        .p_m      (p_m_r),
        .a        (a),
        .j        (j),
        .m        (m),
        .advance  (chk_advance_s),
        .stall    (chk_stall_s),
        .terminal (chk_terminal_s),
        .code     (chk_code_s)
    );

    // Next-state and statistics update; FAIL freezes everything until rst.
    always_comb begin
        state_s     = state_r;
        step_cnt_s  = step_cnt_r;
        stall_cnt_s = stall_cnt_r;
        a_max_s     = a_max_r;
        a_min_s     = a_min_r;
        viol_s      = viol_r;
        code_s      = code_r;
        start_s     = (a == W_ZERO) && (j == W_ONE) && (m == M_INIT_V);

        if (!valid_r || (state_r == ST_FAIL)) begin
            state_s = state_r;
        end else if (dut_rst) begin
            state_s     = ST_IDLE;
            step_cnt_s  = W_ZERO;
            stall_cnt_s = 8'd0;
            a_max_s     = W_ZERO;
            a_min_s     = W_ONES;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_s     = ST_RUN;
                        step_cnt_s  = W_ZERO;
                        stall_cnt_s = 8'd0;
                        a_max_s     = a;
                        a_min_s     = a;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUN, ST_DONE: begin
                    if (chk_code_s != V_NONE) begin
                        state_s = ST_FAIL;
                        viol_s  = 1'b1;
                        code_s  = chk_code_s;
                    end else if (state_r == ST_RUN) begin
                        if (chk_advance_s) begin
                            step_cnt_s  = (step_cnt_r == W_ONES) ? step_cnt_r : step_cnt_r + W_ONE;
                            stall_cnt_s = 8'd0;
                            a_max_s     = (a > a_max_r) ? a : a_max_r;
                            a_min_s     = (a < a_min_r) ? a : a_min_r;
                        end else if (chk_stall_s) begin
                            stall_cnt_s = (stall_cnt_r >= STALL_MAX) ? STALL_MAX : stall_cnt_r + 8'd1;
                        end else begin
                            stall_cnt_s = stall_cnt_r;
                        end
                        state_s = (j > m) ? ST_DONE : ST_RUN;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: begin
                    state_s = state_r;
                end
            endcase
        end
        stuck_s = (stall_cnt_s == STALL_MAX);
    end

    // State, statistics and prev-sample registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            step_cnt_r  <= W_ZERO;
            stall_cnt_r <= 8'd0;
            a_max_r     <= W_ZERO;
            a_min_r     <= W_ONES;
            stuck_r     <= 1'b0;
            viol_r      <= 1'b0;
            code_r      <= V_NONE;
            valid_r     <= 1'b0;
            p_sel_r     <= 1'b0;
            p_a_r       <= W_ZERO;
            p_j_r       <= W_ZERO;
            p_m_r       <= W_ZERO;
        end else begin
            state_r     <= state_s;
            step_cnt_r  <= step_cnt_s;
            stall_cnt_r <= stall_cnt_s;
            a_max_r     <= a_max_s;
            a_min_r     <= a_min_s;
            stuck_r     <= stuck_s;
            viol_r      <= viol_s;
            code_r      <= code_s;
            valid_r     <= 1'b1;
            p_sel_r     <= selector;
            p_a_r       <= a;
            p_j_r       <= j;
            p_m_r       <= m;
        end
    end

    assign state     = state_r;
    assign step_cnt  = step_cnt_r;
    assign stall_cnt = stall_cnt_r;
    assign a_max     = a_max_r;
    assign a_min     = a_min_r;
    assign stuck     = stuck_r;
    assign viol      = viol_r;
    assign viol_code = code_r;

endmodule

// File: tb/tb_fib_trace_monitor.sv
// Directed scoreboard bench for fib_trace_monitor: a legal upstream model drives a/j/m,
// expectations are queued at drive time and popped after the sampling edge.
module tb_fib_trace_monitor;

    logic        clk, clk_en, rst, dut_rst, selector;
    logic [10:0] a, j, m;
    logic [1:0]  state;
    logic [10:0] step_cnt, a_max, a_min;
    logic [7:0]  stall_cnt;
    logic        stuck, viol;
    logic [1:0]  viol_code;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0]  IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, FAILST = 2'd3;
    localparam logic [10:0] AMIN_RST = 11'h7FF;

    typedef struct {
        string       tag;
        logic [1:0]  st;
        logic [10:0] step;
        logic [7:0]  stall;
        logic [10:0] amax;
        logic [10:0] amin;
        logic        stk;
        logic        vl;
        logic [1:0]  code;
    } exp_t;

    exp_t sb[$];

    logic        b_sel;
    logic [10:0] b_a, b_j, b_m;

    fib_trace_monitor dut (
        .clk       (clk),
        .rst       (rst),
        .dut_rst   (dut_rst),
        .selector  (selector),
        .a         (a),
        .j         (j),
        .m         (m),
        .state     (state),
        .step_cnt  (step_cnt),
        .stall_cnt (stall_cnt),
        .a_max     (a_max),
        .a_min     (a_min),
        .stuck     (stuck),
        .viol      (viol),
        .viol_code (viol_code)
    );

    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [1:0] st, input logic [10:0] step,
                        input logic [7:0] stall, input logic [10:0] amax, input logic [10:0] amin,
                        input logic stk, input logic vl, input logic [1:0] code);
        exp_t e;
        e.tag = tag; e.st = st; e.step = step; e.stall = stall; e.amax = amax;
        e.amin = amin; e.stk = stk; e.vl = vl; e.code = code;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        e = sb.pop_front();
        cmp({e.tag, ".state"},     16'(state),     16'(e.st));
        cmp({e.tag, ".step_cnt"},  16'(step_cnt),  16'(e.step));
        cmp({e.tag, ".stall_cnt"}, 16'(stall_cnt), 16'(e.stall));
        cmp({e.tag, ".a_max"},     16'(a_max),     16'(e.amax));
        cmp({e.tag, ".a_min"},     16'(a_min),     16'(e.amin));
        cmp({e.tag, ".stuck"},     16'(stuck),     16'(e.stk));
        cmp({e.tag, ".viol"},      16'(viol),      16'(e.vl));
        cmp({e.tag, ".viol_code"}, 16'(viol_code), 16'(e.code));
    endtask

    task automatic push_reset(input string tag);
        push(tag, IDLE, 11'd0, 8'd0, 11'd0, AMIN_RST, 1'b0, 1'b0, 2'd0);
    endtask

    // Drive one sample, let the monitor take it, and land 1 time unit past the edge.
    task automatic cyc(input logic dr, input logic s, input logic [10:0] av,
                       input logic [10:0] jv, input logic [10:0] mv);
        dut_rst = dr; selector = s; a = av; j = jv; m = mv;
        b_sel = s; b_a = av; b_j = jv; b_m = mv;
        @(posedge clk);
        #1;
    endtask

    // Legal upstream: next a/j derived from the previously driven sample.
    task automatic model_step(input logic s);
        logic [10:0] na, nj;
        if (b_j > b_m) begin
            na = b_a; nj = b_j;
        end else if (b_sel) begin
            na = b_a + 11'd1; nj = b_j + 11'd1;
        end else if (b_a != 11'd0) begin
            na = b_a - 11'd1; nj = b_j + 11'd1;
        end else begin
            na = b_a; nj = b_j;
        end
        cyc(1'b0, s, na, nj, b_m);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        clk_en = 1'b0; rst = 1'b0; dut_rst = 1'b0; selector = 1'b0;
        a = 11'd0; j = 11'd1; m = 11'd300;
        b_sel = 1'b0; b_a = 11'd0; b_j = 11'd1; b_m = 11'd300;

        // Reset with no clock running.
        #3 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        push_reset("t1_async"); pop_check();
        clk_en = 1'b1;

        push_reset("t1_dutrst"); cyc(1'b1, 1'b0, 11'd0, 11'd1, 11'd300); pop_check();
        push("t1_start", RUN, 11'd0, 8'd0, 11'd0, 11'd0, 1'b0, 1'b0, 2'd0);
        cyc(1'b0, 1'b1, 11'd0, 11'd1, 11'd300); pop_check();

        // Selector held high: 300 advances reach a=300, j=301.
        repeat (149) model_step(1'b1);
        push("t2_mid", RUN, 11'd150, 8'd0, 11'd150, 11'd0, 1'b0, 1'b0, 2'd0);
        model_step(1'b1); pop_check();
        repeat (149) model_step(1'b1);
        push("t2_done", DONE, 11'd300, 8'd0, 11'd300, 11'd0, 1'b0, 1'b0, 2'd0);
        model_step(1'b1); pop_check();
        cmp("t2_a_model", 16'(b_a), 16'd300);
        push("t2_hold", DONE, 11'd300, 8'd0, 11'd300, 11'd0, 1'b0, 1'b0, 2'd0);
        model_step(1'b1); pop_check();

        // Stalls with selector low, saturation, then one advance up and one down.
        push_reset("t3_dutrst"); cyc(1'b1, 1'b0, 11'd300, 11'd301, 11'd300); pop_check();
        push("t3_start", RUN, 11'd0, 8'd0, 11'd0, 11'd0, 1'b0, 1'b0, 2'd0);
        cyc(1'b0, 1'b0, 11'd0, 11'd1, 11'd300); pop_check();
        repeat (6) model_step(1'b0);
        push("t3_stall7", RUN, 11'd0, 8'd7, 11'd0, 11'd0, 1'b0, 1'b0, 2'd0);
        model_step(1'b0); pop_check();
        push("t3_stall8", RUN, 11'd0, 8'd8, 11'd0, 11'd0, 1'b1, 1'b0, 2'd0);
        model_step(1'b0); pop_check();
        push("t3_stall_sat", RUN, 11'd0, 8'd8, 11'd0, 11'd0, 1'b1, 1'b0, 2'd0);
        model_step(1'b1); pop_check();
        push("t3_up", RUN, 11'd1, 8'd0, 11'd1, 11'd0, 1'b0, 1'b0, 2'd0);
        model_step(1'b0); pop_check();
        push("t3_down", RUN, 11'd2, 8'd0, 11'd1, 11'd0, 1'b0, 1'b0, 2'd0);
        model_step(1'b0); pop_check();

        // Illegal jump after 5 up-steps; FAIL survives dut_rst.
        push_reset("t4_dutrst"); cyc(1'b1, 1'b0, 11'd0, 11'd3, 11'd300); pop_check();
        push("t4_start", RUN, 11'd0, 8'd0, 11'd0, 11'd0, 1'b0, 1'b0, 2'd0);
        cyc(1'b0, 1'b1, 11'd0, 11'd1, 11'd300); pop_check();
        repeat (4) model_step(1'b1);
        push("t4_five", RUN, 11'd5, 8'd0, 11'd5, 11'd0, 1'b0, 1'b0, 2'd0);
        model_step(1'b1); pop_check();
        push("t4_illegal", FAILST, 11'd5, 8'd0, 11'd5, 11'd0, 1'b0, 1'b1, 2'd1);
        cyc(1'b0, 1'b1, 11'd7, 11'd7, 11'd300); pop_check();
        push("t4_dutrst_fail", FAILST, 11'd5, 8'd0, 11'd5, 11'd0, 1'b0, 1'b1, 2'd1);
        cyc(1'b1, 1'b0, 11'd7, 11'd7, 11'd300); pop_check();
        push("t4_after", FAILST, 11'd5, 8'd0, 11'd5, 11'd0, 1'b0, 1'b1, 2'd1);
        cyc(1'b0, 1'b0, 11'd0, 11'd1, 11'd300); pop_check();

        // m change together with an illegal step: M_CHANGED wins.
        pulse_rst();
        push_reset("t5_rst"); pop_check();
        push_reset("t5_first_edge"); cyc(1'b0, 1'b1, 11'd0, 11'd1, 11'd300); pop_check();
        push("t5_start", RUN, 11'd0, 8'd0, 11'd0, 11'd0, 1'b0, 1'b0, 2'd0);
        cyc(1'b0, 1'b1, 11'd0, 11'd1, 11'd300); pop_check();
        push("t5_step", RUN, 11'd1, 8'd0, 11'd1, 11'd0, 1'b0, 1'b0, 2'd0);
        model_step(1'b1); pop_check();
        push("t5_mchg", FAILST, 11'd1, 8'd0, 11'd1, 11'd0, 1'b0, 1'b1, 2'd2);
        cyc(1'b0, 1'b1, 11'd3, 11'd3, 11'd299); pop_check();

        // a and j both beyond m with m stable: INVARIANT outranks ILLEGAL_STEP.
        pulse_rst();
        cyc(1'b0, 1'b1, 11'd0, 11'd1, 11'd300);
        push("t5b_start", RUN, 11'd0, 8'd0, 11'd0, 11'd0, 1'b0, 1'b0, 2'd0);
        cyc(1'b0, 1'b1, 11'd0, 11'd1, 11'd300); pop_check();
        push("t5b_inv", FAILST, 11'd0, 8'd0, 11'd0, 11'd0, 1'b0, 1'b1, 2'd3);
        cyc(1'b0, 1'b1, 11'd301, 11'd302, 11'd300); pop_check();

        // Async rst in the middle of a run, between clock edges.
        pulse_rst();
        cyc(1'b0, 1'b1, 11'd0, 11'd1, 11'd300);
        cyc(1'b0, 1'b1, 11'd0, 11'd1, 11'd300);
        repeat (2) model_step(1'b1);
        push("t6_run", RUN, 11'd3, 8'd0, 11'd3, 11'd0, 1'b0, 1'b0, 2'd0);
        model_step(1'b1); pop_check();
        rst = 1'b1;
        #1;
        push_reset("t6_async"); pop_check();
        rst = 1'b0;
        push_reset("t6_post"); model_step(1'b1); pop_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
